// File: rtl/vec_pkg.sv
// Shared vector-datapath definitions: lane geometry, the packed vector type
// and the operand-loader state encoding.
package vec_pkg;

  localparam int ELEMENT = 16;
  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = $clog2(ELEMENT);

  typedef logic [ELEMENT-1:0][WIDTH-1:0] vector_t;

  typedef enum logic [1:0] {
    VLD_IDLE  = 2'd0,
    VLD_ISSUE = 2'd1,
    VLD_DRAIN = 2'd2,
    VLD_DONE  = 2'd3
  } vld_state_t;

endpackage

// File: rtl/vec_addr_gen.sv
// Address generator for the vector loader: latches base/stride/mode on load,
// walks a wrapping address and counts issues, flagging the final one.
module vec_addr_gen
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic              bcast,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              bcast_mode,
  output logic              last_issue
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic              bcast_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      stride_reg    <= '0;
      bcast_reg     <= 1'b0;
      issue_cnt_reg <= '0;
    end else if (load) begin
      addr_reg      <= base_addr;
      stride_reg    <= stride;
      bcast_reg     <= bcast;
      issue_cnt_reg <= '0;
    end else if (advance) begin
      // Plain modular add: address wrap is intentional and unflagged.
      addr_reg      <= addr_reg + stride_reg;
      issue_cnt_reg <= issue_cnt_reg + 1'b1;
    end
  end

  assign addr       = addr_reg;
  assign bcast_mode = bcast_reg;
  assign last_issue = bcast_reg || (issue_cnt_reg == CNT_W'(ELEMENT - 1));

endmodule

// File: rtl/vec_load_unit.sv
// Vector operand loader: issues ELEMENT strided reads (or one broadcast read)
// and packs the returned words into a lane-indexed vector register.
module vec_load_unit
  import vec_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [ADDR_W-1:0]               stride,
  input  logic                            bcast,
  output logic                            mem_rd_en,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [WIDTH-1:0]                mem_rdata,
  output logic [ELEMENT-1:0][WIDTH-1:0]   vector_out,
  output logic                            busy,
  output logic                            done
);

  vld_state_t        state_reg, state_next;
  logic              cap_valid_reg;
  logic [CNT_W-1:0]  cap_cnt_reg;
  logic              accept;
  logic              issuing;
  logic              last_issue;
  logic              bcast_mode;
  logic [ADDR_W-1:0] gen_addr;

  assign accept  = (state_reg == VLD_IDLE) && start;
  assign issuing = (state_reg == VLD_ISSUE);

  vec_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .base_addr  (base_addr),
    .stride     (stride),
    .bcast      (bcast),
    .advance    (issuing),
    .addr       (gen_addr),
    .bcast_mode (bcast_mode),
    .last_issue (last_issue)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      VLD_IDLE:  if (start) state_next = VLD_ISSUE;
      VLD_ISSUE: if (last_issue) state_next = VLD_DRAIN;
      VLD_DRAIN: state_next = VLD_DONE;
      VLD_DONE:  state_next = VLD_IDLE;
      default:   state_next = VLD_IDLE;
    endcase
  end

  // cap_valid_reg marks the cycle where the previous issue's data is on mem_rdata;
  // clearing it on reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= VLD_IDLE;
      cap_valid_reg <= 1'b0;
      cap_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cap_valid_reg <= issuing;
      if (accept)
        cap_cnt_reg <= '0;
      else if (cap_valid_reg)
        cap_cnt_reg <= cap_cnt_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < ELEMENT; gi++) begin : g_lane
    logic             lane_we;
    logic [WIDTH-1:0] lane_reg;

    assign lane_we = cap_valid_reg && (bcast_mode || (cap_cnt_reg == CNT_W'(gi)));

    always_ff @(posedge clk) begin
      if (rst)
        lane_reg <= '0;
      else if (lane_we)
        lane_reg <= mem_rdata;
    end

    assign vector_out[gi] = lane_reg;
  end

  assign mem_rd_en = issuing;
  assign mem_addr  = issuing ? gen_addr : '0;
  assign busy      = (state_reg == VLD_ISSUE) || (state_reg == VLD_DRAIN);
  assign done      = (state_reg == VLD_DONE);

endmodule

// File: tb/tb_vec_load_unit.sv
// Self-checking bench for vec_load_unit: per-cycle comparison against a
// phase-based behavioural model plus directed literal expectations.
module tb_vec_load_unit;
  import vec_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic              bcast;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic [ELEMENT-1:0][WIDTH-1:0] vector_out;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_total = 0;
  int busy_total = 0;
  int done_total = 0;

  vec_load_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .stride     (stride),
    .bcast      (bcast),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .vector_out (vector_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: mem[a] = a + 0x1000, one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem_rd_en ? 16'(mem_addr + 16'h1000) : 16'hBAD0;

  always @(negedge clk) begin
    if (mem_rd_en) rd_total <= rd_total + 1;
    if (busy)      busy_total <= busy_total + 1;
    if (done)      done_total <= done_total + 1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vector_t model_vec(input logic [15:0] b, input logic [15:0] s, input bit bc);
    vector_t v;
    for (int i = 0; i < ELEMENT; i++)
      v[i] = bc ? 16'(b + 16'h1000) : 16'(int'(b) + i * int'(s) + 'h1000);
    return v;
  endfunction

  // Behavioural model: phase = cycles since the accepted start (-1 when idle).
  int          m_phase = -1;
  int          m_n;
  logic [15:0] m_base = '0;
  logic [15:0] m_stride = '0;
  bit          m_bcast = 1'b0;
  vector_t     m_vec = '0;
  bit          exp_rd;
  logic [15:0] exp_addr;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      m_n      = m_bcast ? 1 : ELEMENT;
      exp_rd   = (m_phase >= 1) && (m_phase <= m_n);
      exp_addr = exp_rd ? 16'(int'(m_base) + (m_phase - 1) * int'(m_stride)) : 16'h0;
      check("rd_en", 256'(mem_rd_en), 256'(exp_rd));
      check("addr", 256'(mem_addr), 256'(exp_addr));
      check("busy", 256'(busy), 256'((m_phase >= 1) && (m_phase <= m_n + 1)));
      check("done", 256'(done), 256'(m_phase == m_n + 2));
      if (m_phase <= 2 || m_phase == m_n + 2)
        check("vector", vector_out, m_vec);
      if (rst) begin
        m_phase = -1;
        m_vec   = '0;
      end else if (m_phase == -1) begin
        if (start) begin
          m_phase  = 1;
          m_base   = base_addr;
          m_stride = stride;
          m_bcast  = bcast;
        end
      end else if (m_phase == m_n + 2) begin
        m_phase = -1;
      end else begin
        m_phase++;
        if (m_phase == m_n + 2) m_vec = model_vec(m_base, m_stride, m_bcast);
      end
    end
  end

  task automatic run_load(input logic [15:0] b, input logic [15:0] s, input bit bc, input bit hold,
                          output int dcyc, output int rds, output int bsy, output vector_t v);
    int t0, rd0, b0;
    bit seen;
    @(posedge clk); #1;
    base_addr = b; stride = s; bcast = bc; start = 1'b1;
    t0 = cyc; rd0 = rd_total; b0 = busy_total;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    seen = 1'b0; dcyc = -1; v = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; dcyc = cyc - t0; v = vector_out;
      end
    end
    start = 1'b0;
    #1;
    rds = rd_total - rd0;
    bsy = busy_total - b0;
    if (!seen) check("done_timeout", 256'(0), 256'(1));
  endtask

  int dcyc, rds, bsy, t0, d0;
  vector_t v, vb;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; bcast = 1'b0;
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_done", 256'(done), 256'(0));
    check("reset_rd_en", 256'(mem_rd_en), 256'(0));
    check("reset_addr", 256'(mem_addr), 256'(0));
    check("reset_vector", vector_out, 256'(0));
    rst = 1'b0;

    run_load(16'h0100, 16'd1, 1'b0, 1'b0, dcyc, rds, bsy, v);
    $display("[TB] normal base=0100 stride=1 done@%0d rd=%0d busy=%0d lane0=%h lane15=%h", dcyc, rds, bsy, v[0], v[15]);
    check("normal_done_cycle", 256'(dcyc), 256'(18));
    check("normal_rd_count", 256'(rds), 256'(16));
    check("normal_busy_count", 256'(bsy), 256'(17));
    check("normal_lane0", 256'(v[0]), 256'(16'h1100));
    check("normal_lane9", 256'(v[9]), 256'(16'h1109));
    check("normal_lane15", 256'(v[15]), 256'(16'h110F));

    run_load(16'h0020, 16'd1, 1'b1, 1'b0, dcyc, rds, bsy, vb);
    $display("[TB] bcast base=0020 done@%0d rd=%0d lane0=%h lane15=%h", dcyc, rds, vb[0], vb[15]);
    check("bcast_done_cycle", 256'(dcyc), 256'(3));
    check("bcast_rd_count", 256'(rds), 256'(1));
    check("bcast_lane0", 256'(vb[0]), 256'(16'h1020));
    check("bcast_lane15", 256'(vb[15]), 256'(16'h1020));

    run_load(16'hFFFE, 16'd1, 1'b0, 1'b0, dcyc, rds, bsy, v);
    $display("[TB] wrap base=FFFE stride=1 done@%0d lane0=%h lane1=%h lane2=%h", dcyc, v[0], v[1], v[2]);
    check("wrap_lane0", 256'(v[0]), 256'(16'h0FFE));
    check("wrap_lane2", 256'(v[2]), 256'(16'h1000));
    check("wrap_lane15", 256'(v[15]), 256'(16'h100D));

    run_load(16'h0000, 16'd4, 1'b0, 1'b0, dcyc, rds, bsy, v);
    $display("[TB] stride4 base=0000 done@%0d lane15=%h", dcyc, v[15]);
    check("stride4_lane15", 256'(v[15]), 256'(16'h103C));

    d0 = done_total;
    run_load(16'h0200, 16'd3, 1'b0, 1'b1, dcyc, rds, bsy, v);
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] held start base=0200 stride=3 done@%0d rd=%0d dones=%0d lane1=%h", dcyc, rds, done_total - d0, v[1]);
    check("hold_rd_count", 256'(rds), 256'(16));
    check("hold_done_count", 256'(done_total - d0), 256'(1));
    check("hold_lane1", 256'(v[1]), 256'(16'h1203));

    @(posedge clk); #1;
    base_addr = 16'h0500; stride = 16'd1; bcast = 1'b0; start = 1'b1;
    t0 = cyc; d0 = done_total;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] rst in cycle 8: busy=%0d rd_en=%0d vector_zero=%0d", busy, mem_rd_en, vector_out == '0);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_rd_en", 256'(mem_rd_en), 256'(0));
    check("rst_vector", vector_out, 256'(0));
    repeat (25) @(posedge clk);
    #1;
    check("rst_no_done", 256'(done_total - d0), 256'(0));

    run_load(16'h0300, 16'd2, 1'b0, 1'b0, dcyc, rds, bsy, v);
    $display("[TB] after rst base=0300 stride=2 done@%0d lane5=%h", dcyc, v[5]);
    check("post_rst_done_cycle", 256'(dcyc), 256'(18));
    check("post_rst_lane5", 256'(v[5]), 256'(16'h130A));

    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; base_addr = 16'h0700; stride = 16'd1; bcast = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    $display("[TB] rst with start: busy=%0d rd_en=%0d", busy, mem_rd_en);
    check("rst_start_busy", 256'(busy), 256'(0));
    check("rst_start_rd_en", 256'(mem_rd_en), 256'(0));

    run_load(16'h0042, 16'd0, 1'b0, 1'b0, dcyc, rds, bsy, v);
    run_load(16'h0042, 16'd0, 1'b1, 1'b0, dcyc, d0, bsy, vb);
    $display("[TB] stride0 base=0042 rd=%0d lane7=%h; bcast rd=%0d", rds, v[7], d0);
    check("stride0_rd_count", 256'(rds), 256'(16));
    check("stride0_lane7", 256'(v[7]), 256'(16'h1042));
    check("stride0_vs_bcast", v, vb);
    check("bcast0042_rd_count", 256'(d0), 256'(1));

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
